prach_nco_mc: RTL
=================

Name: prach_nco_mc

Overview:
- Parametrised multi-channel TDM numerically controlled oscillator (NCO) for the PRACH down-conversion path.
- Sits between the channel-interleaved sample scheduler and the complex mixer.
- Each time a channel slot arrives, it outputs the cos/sin pair for that channel's current phase, then advances that channel's phase by its frequency control word (FCW).
- Over the previous NCO it adds: configurable channel count, configurable accumulator and output widths, a quarter-wave LUT, a per-channel phase offset, and FCW/offset shadowing that is committed on sync.

Parameters:
- NUM_CHN, 8, number of interleaved channels (1..256).
- ACC_W, 24, phase accumulator width; phase wraps mod 2^ACC_W.
- LUT_AW, 10, quarter-wave LUT address width; N = 2^LUT_AW entries; requires ACC_W >= LUT_AW+2.
- DOUT_W, 16, signed output width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- din_dv  in  1  channel slot valid
- din_chn  in  8  channel index of the slot
- sync_in  in  1  frame sync: restart all accumulators and commit shadow controls
- ctrl_fcw  in  NUM_CHN x ACC_W  per-channel FCW, unsigned, quasi-static
- ctrl_phase_ofs  in  NUM_CHN x ACC_W  per-channel phase offset, quasi-static
- dout_cos  out  DOUT_W  signed cosine
- dout_sin  out  DOUT_W  signed sine
- dout_dv  out  1  din_dv delayed by LATENCY
- dout_chn  out  8  din_chn delayed by LATENCY
- sync_out  out  1  sync_in delayed by LATENCY

Behaviour:
- LATENCY = 4, fixed. Input sampled at cycle t appears on the outputs at cycle t+4. dout_dv, dout_chn and sync_out are delayed through the same pipeline.
- Reset (rst_n=0 at a clock edge):
  - all acc, active fcw and active ofs cleared to 0;
  - all pipeline stages cleared;
  - dout_cos = dout_sin = 0, dout_dv = 0, dout_chn = 0, sync_out = 0, held for the 4 cycles after release until valid data flushes through.
  - Reset mid-stream discards all in-flight samples.
- Controls: ctrl_fcw and ctrl_phase_ofs are copied into the active registers only at a sync_in cycle. Changes between syncs have no effect.
- Slot processing when din_dv=1 and din_chn < NUM_CHN, channel c:
  - phase = (acc[c] + ofs[c]) mod 2^ACC_W, using the pre-update acc;
  - then acc[c] <= (acc[c] + fcw[c]) mod 2^ACC_W.
  - Other channels' accumulators are untouched.
- Slot with din_chn >= NUM_CHN: dout_dv and dout_chn propagate normally, cos/sin output 0, no accumulator changes.
- din_dv=0: no accumulator update. The cos/sin outputs for that slot are don't-care, but the bench expects them to hold their previous value.
- sync_in=1 (with or without din_dv):
  - all acc treated as 0 and active fcw/ofs loaded from the ctrl inputs in the same cycle;
  - a valid slot in the sync cycle is sample 0: phase = new ofs[c], and acc[c] <= new fcw[c];
  - all other channels' acc <= 0.
- LUT: lut[k] = round(A*sin(2*pi*(k+0.5)/(4N))), k = 0..N-1, A = 2^(DOUT_W-1)-1, rounding half away from zero. The table is unsigned and built at elaboration.
- Phase to amplitude:
  - p = top LUT_AW+2 bits of phase, truncated (no dither);
  - q = p[MSB:MSB-1], i = low LUT_AW bits.
  - sin by quadrant: q0 = +lut[i], q1 = +lut[N-1-i], q2 = -lut[i], q3 = -lut[N-1-i].
  - cos uses the same mapping with quadrant q+1 mod 4.
  - Outputs are never -2^(DOUT_W-1); no exact zeros; sin/cos symmetry is exact.
- Back-to-back slots on every cycle, including the same channel on consecutive cycles, must be supported at full rate. The update for one slot is visible to the next slot on the next cycle.

Test Plan:
- Defaults, sync with ctrl_fcw[0] = 2^22, ofs = 0, then chn 0 valid for 4 consecutive cycles, the first coinciding with sync -> sin = 25, 32767, -25, -32767; cos = 32767, -25, -32767, 25, each at t+4; sync_out high with the first output.
- ctrl_phase_ofs[3] = 2^23, fcw[3] = 0, sync, chn 3 slots -> constant sin = -25, cos = -32767. Changing ofs without a new sync -> output unchanged.
- 8-channel round robin, fcw[c] = c*2^18, 1000 rounds -> each channel's phase matches the model mod 2^24. Checks wrap-around and that channels stay isolated.
- din_chn = 9 with NUM_CHN = 8, and gaps with din_dv = 0 -> dout_dv follows the input with 4-cycle delay, cos/sin = 0 for the invalid channel, no accumulator changes.
- Reset asserted mid-stream for 1 cycle -> outputs 0 and dout_dv = 0 for 4 cycles. The next sample of any channel uses phase = 0 with ofs = 0: sin = 25, cos = 32767.
- Re-run with NUM_CHN = 3, ACC_W = 32, LUT_AW = 8, DOUT_W = 18 against the reference model -> bit-exact match.

Source files
------------

// File: rtl/prach_nco_mc.sv
// Multi-channel TDM NCO: per-slot cos/sin from a quarter-wave LUT, then per-channel phase advance.
// Fixed 4-cycle latency at full slot rate, no backpressure; controls take effect only on sync.
`timescale 1ns/1ps
module prach_nco_mc #(
  parameter int NUM_CHN = 8,
  parameter int ACC_W   = 24,
  parameter int LUT_AW  = 10,
  parameter int DOUT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       din_dv,
  input  logic [7:0]                 din_chn,
  input  logic                       sync_in,
  input  logic [NUM_CHN*ACC_W-1:0]   ctrl_fcw,
  input  logic [NUM_CHN*ACC_W-1:0]   ctrl_phase_ofs,
  output logic signed [DOUT_W-1:0]   dout_cos,
  output logic signed [DOUT_W-1:0]   dout_sin,
  output logic                       dout_dv,
  output logic [7:0]                 dout_chn,
  output logic                       sync_out
);

  localparam int  N   = 1 << LUT_AW;
  localparam int  PW  = LUT_AW + 2;
  localparam int  MW  = DOUT_W - 1;
  localparam int  AMP = (1 << MW) - 1;
  localparam real PI  = 3.14159265358979323846;

  // Taylor series keeps the table build free of tool-specific math builtins.
  function automatic logic [MW-1:0] lut_val(input int k);
    real x, term, s;
    x    = 2.0 * PI * (real'(k) + 0.5) / (4.0 * real'(N));
    term = x;
    s    = x;
    for (int n = 1; n < 14; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      s    = s + term;
    end
    return MW'($rtoi(real'(AMP) * s + 0.5));
  endfunction

  logic [MW-1:0] lut [N];
  for (genvar k = 0; k < N; k++) begin : g_lut
    localparam logic [MW-1:0] LUT_V = lut_val(k);
    assign lut[k] = LUT_V;
  end

  logic [ACC_W-1:0] acc_q [NUM_CHN];
  logic [ACC_W-1:0] acc_d [NUM_CHN];
  logic [ACC_W-1:0] fcw_q [NUM_CHN];
  logic [ACC_W-1:0] fcw_d [NUM_CHN];
  logic [ACC_W-1:0] ofs_q [NUM_CHN];
  logic [ACC_W-1:0] ofs_d [NUM_CHN];
  logic [ACC_W-1:0] phase0, fcw_sel, ofs_sel, acc_cur;

  logic          s1_vld_q, s1_vld_d, s1_sync_q, s1_sync_d, s1_ok_q, s1_ok_d;
  logic [7:0]    s1_chn_q, s1_chn_d;
  logic [PW-1:0] s1_p_q, s1_p_d;

  logic              s2_vld_q, s2_vld_d, s2_sync_q, s2_sync_d, s2_ok_q, s2_ok_d;
  logic [7:0]        s2_chn_q, s2_chn_d;
  logic [LUT_AW-1:0] s2_sin_addr_q, s2_sin_addr_d, s2_cos_addr_q, s2_cos_addr_d;
  logic              s2_sin_neg_q, s2_sin_neg_d, s2_cos_neg_q, s2_cos_neg_d;

  logic          s3_vld_q, s3_vld_d, s3_sync_q, s3_sync_d, s3_ok_q, s3_ok_d;
  logic [7:0]    s3_chn_q, s3_chn_d;
  logic [MW-1:0] s3_sin_mag_q, s3_sin_mag_d, s3_cos_mag_q, s3_cos_mag_d;
  logic          s3_sin_neg_q, s3_sin_neg_d, s3_cos_neg_q, s3_cos_neg_d;

  logic              dv_q, dv_d, sync_q, sync_d;
  logic [7:0]        chn_q, chn_d;
  logic [DOUT_W-1:0] cos_q, cos_d, sin_q, sin_d;
  logic [DOUT_W-1:0] sin_ext, cos_ext;

  logic [1:0]        quad;
  logic [LUT_AW-1:0] idx;
  assign quad    = s1_p_q[PW-1 -: 2];
  assign idx     = s1_p_q[LUT_AW-1:0];
  assign sin_ext = {1'b0, s3_sin_mag_q};
  assign cos_ext = {1'b0, s3_cos_mag_q};

  always_comb begin
    acc_d   = acc_q;
    fcw_d   = fcw_q;
    ofs_d   = ofs_q;
    phase0  = '0;
    fcw_sel = '0;
    ofs_sel = '0;
    acc_cur = '0;
    // Sync zeroes every accumulator and loads controls in the same cycle a slot may use them.
    for (int c = 0; c < NUM_CHN; c++) begin
      fcw_sel  = sync_in ? ctrl_fcw[c*ACC_W +: ACC_W]       : fcw_q[c];
      ofs_sel  = sync_in ? ctrl_phase_ofs[c*ACC_W +: ACC_W] : ofs_q[c];
      acc_cur  = sync_in ? '0 : acc_q[c];
      fcw_d[c] = fcw_sel;
      ofs_d[c] = ofs_sel;
      acc_d[c] = acc_cur;
      if (din_dv && (din_chn == 8'(c))) begin
        phase0   = acc_cur + ofs_sel;
        acc_d[c] = acc_cur + fcw_sel;
      end
    end

    s1_vld_d  = din_dv;
    s1_chn_d  = din_chn;
    s1_sync_d = sync_in;
    s1_ok_d   = ({1'b0, din_chn} < 9'(NUM_CHN));
    s1_p_d    = PW'(phase0 >> (ACC_W - PW));

    // Odd quadrants read the table mirrored; cosine is sine one quadrant ahead.
    s2_vld_d      = s1_vld_q;
    s2_chn_d      = s1_chn_q;
    s2_sync_d     = s1_sync_q;
    s2_ok_d       = s1_ok_q;
    s2_sin_addr_d = quad[0] ? ~idx : idx;
    s2_cos_addr_d = quad[0] ? idx : ~idx;
    s2_sin_neg_d  = quad[1];
    s2_cos_neg_d  = quad[1] ^ quad[0];

    s3_vld_d     = s2_vld_q;
    s3_chn_d     = s2_chn_q;
    s3_sync_d    = s2_sync_q;
    s3_ok_d      = s2_ok_q;
    s3_sin_mag_d = lut[s2_sin_addr_q];
    s3_cos_mag_d = lut[s2_cos_addr_q];
    s3_sin_neg_d = s2_sin_neg_q;
    s3_cos_neg_d = s2_cos_neg_q;

    dv_d   = s3_vld_q;
    chn_d  = s3_chn_q;
    sync_d = s3_sync_q;
    cos_d  = cos_q;
    sin_d  = sin_q;
    if (s3_vld_q) begin
      cos_d = s3_ok_q ? (s3_cos_neg_q ? -cos_ext : cos_ext) : '0;
      sin_d = s3_ok_q ? (s3_sin_neg_q ? -sin_ext : sin_ext) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CHN; c++) begin
        acc_q[c] <= '0;
        fcw_q[c] <= '0;
        ofs_q[c] <= '0;
      end
      s1_vld_q <= 1'b0; s1_sync_q <= 1'b0; s1_ok_q <= 1'b0;
      s1_chn_q <= '0;   s1_p_q    <= '0;
      s2_vld_q <= 1'b0; s2_sync_q <= 1'b0; s2_ok_q <= 1'b0; s2_chn_q <= '0;
      s2_sin_addr_q <= '0; s2_cos_addr_q <= '0;
      s2_sin_neg_q  <= 1'b0; s2_cos_neg_q <= 1'b0;
      s3_vld_q <= 1'b0; s3_sync_q <= 1'b0; s3_ok_q <= 1'b0; s3_chn_q <= '0;
      s3_sin_mag_q <= '0; s3_cos_mag_q <= '0;
      s3_sin_neg_q <= 1'b0; s3_cos_neg_q <= 1'b0;
      dv_q  <= 1'b0; sync_q <= 1'b0; chn_q <= '0;
      cos_q <= '0;   sin_q  <= '0;
    end else begin
      acc_q <= acc_d;
      fcw_q <= fcw_d;
      ofs_q <= ofs_d;
      s1_vld_q <= s1_vld_d; s1_sync_q <= s1_sync_d; s1_ok_q <= s1_ok_d;
      s1_chn_q <= s1_chn_d; s1_p_q    <= s1_p_d;
      s2_vld_q <= s2_vld_d; s2_sync_q <= s2_sync_d; s2_ok_q <= s2_ok_d; s2_chn_q <= s2_chn_d;
      s2_sin_addr_q <= s2_sin_addr_d; s2_cos_addr_q <= s2_cos_addr_d;
      s2_sin_neg_q  <= s2_sin_neg_d;  s2_cos_neg_q  <= s2_cos_neg_d;
      s3_vld_q <= s3_vld_d; s3_sync_q <= s3_sync_d; s3_ok_q <= s3_ok_d; s3_chn_q <= s3_chn_d;
      s3_sin_mag_q <= s3_sin_mag_d; s3_cos_mag_q <= s3_cos_mag_d;
      s3_sin_neg_q <= s3_sin_neg_d; s3_cos_neg_q <= s3_cos_neg_d;
      dv_q  <= dv_d;  sync_q <= sync_d; chn_q <= chn_d;
      cos_q <= cos_d; sin_q  <= sin_d;
    end
  end

  assign dout_cos = cos_q;
  assign dout_sin = sin_q;
  assign dout_dv  = dv_q;
  assign dout_chn = chn_q;
  assign sync_out = sync_q;

endmodule
